// File: rtl/move_and_merge_tiles.sv
// One-cycle 2048-style board move: slides and merges every line toward the commanded edge.
// Results are registered; a non-one-hot command passes the board through unchanged.
module move_and_merge_tiles (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  direction,
    input  logic [11:0] board_in  [4][4],
    output logic [11:0] board_out [4][4],
    output logic [19:0] score_update,
    output logic        moved
);

    typedef struct packed {
        logic [3:0][11:0] cells;
        logic [19:0]      score;
    } line_res_t;

    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    // Index 0 of the line is the leading edge.
    function automatic line_res_t slide_line(input logic [3:0][11:0] line);
        logic [4:0][11:0] c;
        logic [2:0]       k;
        logic             skip;
        line_res_t        r;
        c    = '0;
        k    = '0;
        skip = 1'b0;
        r    = '0;
        for (int i = 0; i < 4; i++) begin
            if (line[i] != 12'h000) begin
                c[k] = line[i];
                k    = k + 3'd1;
            end
        end
        k = '0;
        // c[4] is always zero, so the last tile never finds a partner.
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[i] != 12'h000) begin
                if ((c[i] == c[i+1]) && (c[i] < 12'h800)) begin
                    r.cells[k[1:0]] = c[i] << 1;
                    r.score         = r.score + {8'h00, c[i] << 1};
                    skip            = 1'b1;
                end else begin
                    r.cells[k[1:0]] = c[i];
                end
                k = k + 3'd1;
            end
        end
        return r;
    endfunction

    logic [11:0] board_d [4][4];
    logic [11:0] board_q [4][4];
    logic [19:0] score_d, score_q;
    logic        moved_d, moved_q;
    logic        dir_valid;

    assign dir_valid = (direction == DIR_LEFT) || (direction == DIR_UP) ||
                       (direction == DIR_RIGHT) || (direction == DIR_DOWN);

    always_comb begin
        logic [3:0][11:0] line;
        line_res_t        res;
        board_d = board_in;
        score_d = '0;
        moved_d = 1'b0;
        line    = '0;
        res     = '0;
        if (dir_valid) begin
            for (int n = 0; n < 4; n++) begin
                line = '0;
                for (int j = 0; j < 4; j++) begin
                    case (direction)
                        DIR_LEFT:  line[j] = board_in[n][j];
                        DIR_RIGHT: line[j] = board_in[n][3-j];
                        DIR_UP:    line[j] = board_in[j][n];
                        default:   line[j] = board_in[3-j][n];
                    endcase
                end
                res     = slide_line(line);
                score_d = score_d + res.score;
                for (int j = 0; j < 4; j++) begin
                    case (direction)
                        DIR_LEFT:  board_d[n][j]   = res.cells[j];
                        DIR_RIGHT: board_d[n][3-j] = res.cells[j];
                        DIR_UP:    board_d[j][n]   = res.cells[j];
                        default:   board_d[3-j][n] = res.cells[j];
                    endcase
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_d[r][c] != board_in[r][c]) begin
                    moved_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            board_q <= '{default: '0};
            score_q <= '0;
            moved_q <= 1'b0;
        end else begin
            board_q <= board_d;
            score_q <= score_d;
            moved_q <= moved_d;
        end
    end

    assign board_out    = board_q;
    assign score_update = score_q;
    assign moved        = moved_q;

endmodule

// File: tb/tb_move_and_merge_tiles.sv
// Scoreboard bench for move_and_merge_tiles: a queue-based reference model predicts each
// registered result; a monitor pops and compares one prediction per clock.
module tb_move_and_merge_tiles;

    typedef struct {
        logic [11:0] b [4][4];
        logic [19:0] s;
        logic        m;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  direction;
    logic [11:0] board_in  [4][4];
    logic [11:0] board_out [4][4];
    logic [19:0] score_update;
    logic        moved;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    move_and_merge_tiles dut (
        .clk          (clk),
        .rst          (rst),
        .direction    (direction),
        .board_in     (board_in),
        .board_out    (board_out),
        .score_update (score_update),
        .moved        (moved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Maps position j (0 = leading edge) of line n to board coordinates.
    function automatic void line_pos(input logic [3:0] dir, input int n, input int j,
                                     output int r, output int c);
        case (dir)
            4'b0001: begin r = n;     c = j;     end
            4'b0100: begin r = n;     c = 3 - j; end
            4'b0010: begin r = j;     c = n;     end
            default: begin r = 3 - j; c = n;     end
        endcase
    endfunction

    function automatic exp_t ref_move(input logic rst_v, input logic [3:0] dir,
                                      input logic [11:0] bi [4][4]);
        exp_t e;
        int   r, c;
        int   a;
        int   q[$];
        int   o[$];
        e.s = '0;
        e.m = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                e.b[i][k] = rst_v ? 12'h000 : bi[i][k];
        if (rst_v || !(dir inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}))
            return e;
        for (int n = 0; n < 4; n++) begin
            q.delete();
            o.delete();
            for (int j = 0; j < 4; j++) begin
                line_pos(dir, n, j, r, c);
                if (bi[r][c] != 0) q.push_back(int'(bi[r][c]));
            end
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a && a < 'h800) begin
                    void'(q.pop_front());
                    o.push_back(2 * a);
                    e.s = e.s + 20'(2 * a);
                end else begin
                    o.push_back(a);
                end
            end
            while (o.size() < 4) o.push_back(0);
            for (int j = 0; j < 4; j++) begin
                line_pos(dir, n, j, r, c);
                e.b[r][c] = 12'(o[j]);
            end
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                if (e.b[i][k] != bi[i][k]) e.m = 1'b1;
        return e;
    endfunction

    task automatic drive(input logic rst_v, input logic [3:0] dir, input logic [11:0] b [4][4]);
        @(negedge clk);
        rst       = rst_v;
        direction = dir;
        board_in  = b;
        exp_q.push_back(ref_move(rst_v, dir, b));
    endtask

    initial begin : monitor
        exp_t e;
        int   nd;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nd = 0;
                for (int i = 0; i < 4; i++)
                    for (int k = 0; k < 4; k++)
                        if (board_out[i][k] !== e.b[i][k]) begin
                            if (nd == 0)
                                $display("FAIL board cell[%0d][%0d] actual=%h required=%h", i, k, board_out[i][k], e.b[i][k]);
                            nd++;
                        end
                n_checks++;
                if (nd != 0) n_errors++;
                n_checks++;
                if (score_update !== e.s) begin
                    n_errors++;
                    $display("FAIL score_update actual=%h required=%h", score_update, e.s);
                end
                n_checks++;
                if (moved !== e.m) begin
                    n_errors++;
                    $display("FAIL moved actual=%b required=%b", moved, e.m);
                end
            end
        end
    end

    function automatic logic [11:0] rand_tile(input int max_exp);
        int v;
        v = $urandom_range(0, max_exp);
        return (v == 0) ? 12'h000 : 12'(1 << v);
    endfunction

    initial begin : stimulus
        logic [11:0] b [4][4];
        logic [3:0]  d;
        logic [3:0]  dirs [4];
        int          wait_cycles;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        direction = 4'b0000;
        board_in  = '{default: '0};
        dirs      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        b = '{default: '0};
        drive(1'b1, 4'b0000, b);
        drive(1'b1, 4'b0001, b);

        b = '{'{12'h002, 12'h002, 12'h004, 12'h004},
              '{12'h002, 12'h002, 12'h004, 12'h004},
              '{12'h000, 12'h000, 12'h004, 12'h000},
              '{12'h008, 12'h000, 12'h004, 12'h000}};
        drive(1'b0, 4'b0010, b);

        b = '{default: '0};
        b[0] = '{12'h002, 12'h002, 12'h002, 12'h002};
        drive(1'b0, 4'b0001, b);
        b[0] = '{12'h002, 12'h002, 12'h002, 12'h000};
        drive(1'b0, 4'b0100, b);
        b[0] = '{12'h004, 12'h000, 12'h004, 12'h008};
        drive(1'b0, 4'b0001, b);
        b[0] = '{12'h800, 12'h800, 12'h000, 12'h000};
        drive(1'b0, 4'b0001, b);
        b = '{default: '0};
        b[0][0] = 12'h400;
        b[1][0] = 12'h400;
        drive(1'b0, 4'b0010, b);
        drive(1'b0, 4'b1000, b);

        b = '{'{12'h002, 12'h004, 12'h000, 12'h002},
              '{12'h008, 12'h008, 12'h010, 12'h000},
              '{12'h000, 12'h002, 12'h002, 12'h004},
              '{12'h040, 12'h000, 12'h040, 12'h020}};
        drive(1'b0, 4'b0000, b);
        drive(1'b0, 4'b0011, b);
        drive(1'b0, 4'b1100, b);

        b = '{default: '0};
        drive(1'b0, 4'b0001, b);

        b = '{'{12'h400, 12'h400, 12'h400, 12'h400},
              '{12'h400, 12'h400, 12'h400, 12'h400},
              '{12'h400, 12'h400, 12'h400, 12'h400},
              '{12'h400, 12'h400, 12'h400, 12'h400}};
        drive(1'b0, 4'b0100, b);

        b = '{'{12'h002, 12'h002, 12'h000, 12'h000},
              '{12'h004, 12'h000, 12'h004, 12'h000},
              '{12'h000, 12'h000, 12'h000, 12'h000},
              '{12'h008, 12'h008, 12'h008, 12'h000}};
        drive(1'b1, 4'b0001, b);
        drive(1'b0, 4'b0001, b);

        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++)
                    b[i][k] = rand_tile((t % 3 == 0) ? 11 : 3);
            if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(0, 15));
            else d = dirs[$urandom_range(0, 3)];
            drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, d, b);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_and_merge_tiles.md
MOVE_AND_MERGE_TILES -- requirements
Module: move_and_merge_tiles

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 direction  input  4  one-hot move command: 4'b0001 left, 4'b0010 up, 4'b0100 right, 4'b1000 down.
REQ-005 board_in  input  12 x [3:0][3:0] unpacked  current board.
- Index order is [row][col]; row 0 is the top row and col 0 is the left column.
- Each cell holds the literal tile value, e.g. 12'h002, 12'h800; 12'h000 is an empty cell.
REQ-006 board_out  output  12 x [3:0][3:0] unpacked  board after the move, registered, same indexing as board_in.
REQ-007 score_update  output  20  sum of the values of all tiles created by merges in this move, registered.
REQ-008 moved  output  1  registered; 1 when board_out differs from the board_in it was computed from.

Function
REQ-009 Each rising clk edge with rst=0 SHALL sample direction and board_in and register board_out, score_update and moved computed from them; latency exactly 1 cycle, new input accepted every cycle, no handshake.
REQ-010 Line processing is independent per line:
- Up/down: each column. Left/right: each row.
- The leading edge is row 0 (up), row 3 (down), col 0 (left), col 3 (right).
REQ-011 Per line: compact nonzero tiles toward the leading edge, preserving their order.
REQ-012 Then scan from the leading edge and merge each pair of adjacent equal nonzero tiles:
- A merged tile becomes 2x the value.
- A tile takes part in at most one merge per move.
- The line is compacted again after merging.
REQ-013 Merge priority is nearest the leading edge first. Examples for a move toward index 0: 2,2,2,2 -> 4,4,0,0; 2,2,2,0 -> 4,2,0,0; 4,0,4,8 -> 8,8,0,0.
REQ-014 Tiles with value >= 12'h800 SHALL NOT merge, so no 12-bit overflow can occur; otherwise any equal nonzero values merge.
REQ-015 score_update SHALL equal the 20-bit zero-extended sum of all merged result values over all 4 lines; the maximum is 8 x 12'h800, which never overflows.
REQ-016 If direction is not exactly one-hot (zero or multiple bits set), the block SHALL NOT move:
- board_out = board_in.
- score_update = 0.
- moved = 0.
REQ-017 moved = 1 iff any cell of the result differs from board_in; an all-empty board or a board that cannot move gives moved = 0 and score_update = 0.
REQ-018 Outputs SHALL hold their values between edges; no combinational path from inputs to outputs.

Reset
REQ-019 While rst=1 at a rising edge: every board_out cell = 12'h000, score_update = 20'h0, moved = 0.
REQ-020 When rst is asserted mid-stream it overrides the computation on that edge; normal computation resumes on the first edge with rst=0, 1-cycle latency.

Verification
REQ-021 Up move:
- Stimulus: direction=4'b0010, board_in rows (hex) 002 002 004 004 / 002 002 004 004 / 000 000 004 000 / 008 000 004 000.
- Required after 1 edge: board_out rows 004 004 008 008 / 008 000 008 000 / 000 000 000 000 / 000 000 000 000, score_update=20'h00020, moved=1.
REQ-022 Left move:
- Stimulus: direction=4'b0001, row0 = 002 002 002 002, other rows empty.
- Required: row0 = 004 004 000 000, score_update=20'h8, moved=1.
- Stimulus: row0 = 002 002 002 000, direction=4'b0100 (right).
- Required: row0 = 000 000 002 004, score=20'h4.
REQ-023 Saturation:
- Stimulus: row0 = 800 800 000 000, direction left.
- Required: row0 unchanged, score_update=0, moved=0.
- Stimulus: column0 = 400 400 000 000, direction up.
- Required: 800 in row 0, score_update=20'h800.
REQ-024 Invalid direction: direction=4'b0000 and direction=4'b0011 with any board -> board_out = board_in, score_update=0, moved=0.
REQ-025 Reset: rst=1 for one edge while a valid move is applied -> all outputs zero after that edge; rst=0 next edge -> move result appears.
